// File: rtl/mealy_pkg.sv
// Shared constants and helpers for the run detector family.
// Latency: n/a (package).
// Backpressure: n/a (package).
package mealy_pkg;

  // Overlap mode selectors for the OVERLAP parameter.
  localparam int OVERLAP_OFF = 0;
  localparam int OVERLAP_ON  = 1;

  // Width needed to hold run states 0..run_len-1; never narrower than one bit
  // so a RUN_LEN=1 build still has a legal (constant-zero) state vector.
  function automatic int state_width(input int run_len);
    int wd;
    wd = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < run_len) wd = i + 1;
    end
    return (wd < 1) ? 1 : wd;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Latency: q updates one clock after inc/clr; clr wins over inc.
// Backpressure: none; holds at all-ones instead of wrapping.
//
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous active-low reset, forces q to 0
//   clr   - synchronous clear to 0
//   inc   - increment request for this edge
//   q     - count value, W bits
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && !(&q)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/mealy_run_detector.sv
// Mealy detector for RUN_LEN consecutive accepted 1s on serial input w.
// Latency: z is combinational (same cycle as w); y/match_cnt update on the clock edge.
// Backpressure: none; en gates sampling, clear overrides everything synchronously.
//
// Ports:
//   clk       - clock, rising edge
//   reset     - asynchronous active-low reset (y and match_cnt to 0)
//   w         - serial data bit
//   en        - sample enable
//   clear     - synchronous clear of run state and counter
//   z         - match output, combinational
//   y         - consecutive accepted 1s, capped at RUN_LEN-1
//   match_cnt - saturating count of edges with z=1
//
// Build option: define MEALY_RUN_DETECTOR_MATCH_CNT_EN to include the match
// counter; otherwise match_cnt is tied to 0 and no counter flops exist.
module mealy_run_detector
  import mealy_pkg::*;
#(
  parameter  int RUN_LEN = 2,
  parameter  int OVERLAP = OVERLAP_ON,
  parameter  int CNT_W   = 8,
  localparam int SW      = state_width(RUN_LEN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             w,
  input  logic             en,
  input  logic             clear,
  output logic             z,
  output logic [SW-1:0]    y,
  output logic [CNT_W-1:0] match_cnt
);

  // Terminal run state: one more accepted 1 here completes a match.
  localparam logic [SW-1:0] LAST = SW'(RUN_LEN - 1);

  logic [SW-1:0] y_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y <= '0;
    end else begin
      y <= y_nxt;
    end
  end

  // Next state and Mealy output. With RUN_LEN=1 the state is always 0 and
  // equals LAST, so z reduces to en & ~clear & w and y never leaves 0.
  always_comb begin
    z     = 1'b0;
    y_nxt = y;
    if (clear) begin
      y_nxt = '0;
    end else if (en) begin
      if (!w) begin
        y_nxt = '0;
      end else if (y == LAST) begin
        z     = 1'b1;
        // Overlapping runs stay in the terminal state so z stays high while
        // w stays 1; non-overlapping runs start counting afresh.
        y_nxt = (OVERLAP == OVERLAP_ON) ? y : '0;
      end else begin
        y_nxt = y + 1'b1;
      end
    end
  end

`ifdef MEALY_RUN_DETECTOR_MATCH_CNT_EN
  sat_counter #(
    .W(CNT_W)
  ) u_match_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (clear),
    .inc  (z),
    .q    (match_cnt)
  );
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_mealy_run_detector.sv
module tb_mealy_run_detector;

`ifdef MEALY_RUN_DETECTOR_MATCH_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct {
    logic        z;
    logic [31:0] y;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic clk = 1'b0;
  logic reset, w, en, clear;

  always #5 clk = ~clk;

  // RUN_LEN=3 overlapping
  logic       z_a;  logic [1:0] y_a;  logic [7:0] c_a;
  // RUN_LEN=3 non-overlapping
  logic       z_b;  logic [1:0] y_b;  logic [7:0] c_b;
  // RUN_LEN=1, CNT_W=2
  logic       z_c;  logic [0:0] y_c;  logic [1:0] c_c;
  // RUN_LEN=4 overlapping
  logic       z_d;  logic [1:0] y_d;  logic [7:0] c_d;
  // RUN_LEN=2 overlapping
  logic       z_e;  logic [0:0] y_e;  logic [7:0] c_e;

  mealy_run_detector #(.RUN_LEN(3), .OVERLAP(1), .CNT_W(8)) u_a (
    .clk(clk), .reset(reset), .w(w), .en(en), .clear(clear), .z(z_a), .y(y_a), .match_cnt(c_a));
  mealy_run_detector #(.RUN_LEN(3), .OVERLAP(0), .CNT_W(8)) u_b (
    .clk(clk), .reset(reset), .w(w), .en(en), .clear(clear), .z(z_b), .y(y_b), .match_cnt(c_b));
  mealy_run_detector #(.RUN_LEN(1), .OVERLAP(1), .CNT_W(2)) u_c (
    .clk(clk), .reset(reset), .w(w), .en(en), .clear(clear), .z(z_c), .y(y_c), .match_cnt(c_c));
  mealy_run_detector #(.RUN_LEN(4), .OVERLAP(1), .CNT_W(8)) u_d (
    .clk(clk), .reset(reset), .w(w), .en(en), .clear(clear), .z(z_d), .y(y_d), .match_cnt(c_d));
  mealy_run_detector #(.RUN_LEN(2), .OVERLAP(1), .CNT_W(8)) u_e (
    .clk(clk), .reset(reset), .w(w), .en(en), .clear(clear), .z(z_e), .y(y_e), .match_cnt(c_e));

  function automatic logic [31:0] ecnt(input int v);
    return CNT_EN ? 32'(v) : 32'd0;
  endfunction

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1; en = 1'b0; w = 1'b0;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; w = 1'b0; en = 1'b0; clear = 1'b0;
    #1;
    n_checks++;
    if (32'(y_a) !== 32'd0) begin n_fail++; $display("FAIL reset_y_a: got %0h expected 0", y_a); end
    n_checks++;
    if (32'(c_a) !== 32'd0) begin n_fail++; $display("FAIL reset_cnt_a: got %0h expected 0", c_a); end
    n_checks++;
    if (z_a !== 1'b0) begin n_fail++; $display("FAIL reset_z_a: got %b expected 0", z_a); end
    // z still follows w/en during reset with y=0
    w = 1'b1; en = 1'b1;
    #1;
    n_checks++;
    if (z_c !== 1'b1) begin n_fail++; $display("FAIL reset_z_c_comb: got %b expected 1", z_c); end
    n_checks++;
    if (z_a !== 1'b0) begin n_fail++; $display("FAIL reset_z_a_comb: got %b expected 0", z_a); end
    @(posedge clk);
    #1;
    n_checks++;
    if (32'(y_a) !== 32'd0) begin n_fail++; $display("FAIL reset_hold_y_a: got %0h expected 0", y_a); end
    n_checks++;
    if (32'(c_c) !== 32'd0) begin n_fail++; $display("FAIL reset_hold_cnt_c: got %0h expected 0", c_c); end
    @(negedge clk);
    w = 1'b0; en = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_overlap();
    bit wv[6] = '{1, 1, 1, 1, 0, 1};
    bit zv[6] = '{0, 0, 1, 1, 0, 0};
    int yv[6] = '{1, 2, 2, 2, 0, 1};
    int cv[6] = '{0, 0, 1, 2, 2, 2};
    exp_t e;
    do_clear();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      w = wv[i]; en = 1'b1;
      e.z = zv[i]; e.y = 32'(yv[i]); e.cnt = ecnt(cv[i]);
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      n_checks++;
      if (z_a !== e.z) begin n_fail++; $display("FAIL overlap_z[%0d]: got %b expected %b", i, z_a, e.z); end
      @(posedge clk);
      #1;
      n_checks++;
      if (32'(y_a) !== e.y) begin n_fail++; $display("FAIL overlap_y[%0d]: got %0d expected %0d", i, y_a, e.y); end
      n_checks++;
      if (32'(c_a) !== e.cnt) begin n_fail++; $display("FAIL overlap_cnt[%0d]: got %0d expected %0d", i, c_a, e.cnt); end
    end
    // clear overrides en and w: run at y=1, cnt=2 must drop to 0 with z low
    @(negedge clk);
    clear = 1'b1; en = 1'b1; w = 1'b1;
    #1;
    n_checks++;
    if (z_a !== 1'b0) begin n_fail++; $display("FAIL clear_z: got %b expected 0", z_a); end
    @(posedge clk);
    #1;
    n_checks++;
    if (32'(y_a) !== 32'd0) begin n_fail++; $display("FAIL clear_y: got %0d expected 0", y_a); end
    n_checks++;
    if (32'(c_a) !== 32'd0) begin n_fail++; $display("FAIL clear_cnt: got %0d expected 0", c_a); end
    clear = 1'b0;
  endtask

  task automatic test_no_overlap();
    bit zv[6] = '{0, 0, 1, 0, 0, 1};
    int yv[6] = '{1, 2, 0, 1, 2, 0};
    int cv[6] = '{0, 0, 1, 1, 1, 2};
    exp_t e;
    do_clear();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      w = 1'b1; en = 1'b1;
      e.z = zv[i]; e.y = 32'(yv[i]); e.cnt = ecnt(cv[i]);
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      n_checks++;
      if (z_b !== e.z) begin n_fail++; $display("FAIL nolap_z[%0d]: got %b expected %b", i, z_b, e.z); end
      @(posedge clk);
      #1;
      n_checks++;
      if (32'(y_b) !== e.y) begin n_fail++; $display("FAIL nolap_y[%0d]: got %0d expected %0d", i, y_b, e.y); end
      n_checks++;
      if (32'(c_b) !== e.cnt) begin n_fail++; $display("FAIL nolap_cnt[%0d]: got %0d expected %0d", i, c_b, e.cnt); end
    end
  endtask

  task automatic test_enable();
    bit ev[4] = '{1, 0, 1, 1};
    bit zv[4] = '{0, 0, 0, 1};
    int yv[4] = '{1, 1, 2, 2};
    int cv[4] = '{0, 0, 0, 1};
    exp_t e;
    do_clear();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      w = 1'b1; en = ev[i];
      e.z = zv[i]; e.y = 32'(yv[i]); e.cnt = ecnt(cv[i]);
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      n_checks++;
      if (z_a !== e.z) begin n_fail++; $display("FAIL enable_z[%0d]: got %b expected %b", i, z_a, e.z); end
      @(posedge clk);
      #1;
      n_checks++;
      if (32'(y_a) !== e.y) begin n_fail++; $display("FAIL enable_y[%0d]: got %0d expected %0d", i, y_a, e.y); end
      n_checks++;
      if (32'(c_a) !== e.cnt) begin n_fail++; $display("FAIL enable_cnt[%0d]: got %0d expected %0d", i, c_a, e.cnt); end
    end
  endtask

  task automatic test_saturate();
    int cv[6] = '{1, 2, 3, 3, 3, 0};
    exp_t e;
    do_clear();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      w = 1'b1; en = 1'b1; clear = (i == 5);
      e.z = (i != 5); e.y = 32'd0; e.cnt = ecnt(cv[i]);
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      n_checks++;
      if (z_c !== e.z) begin n_fail++; $display("FAIL sat_z[%0d]: got %b expected %b", i, z_c, e.z); end
      @(posedge clk);
      #1;
      n_checks++;
      if (32'(y_c) !== e.y) begin n_fail++; $display("FAIL sat_y[%0d]: got %0d expected %0d", i, y_c, e.y); end
      n_checks++;
      if (32'(c_c) !== e.cnt) begin n_fail++; $display("FAIL sat_cnt[%0d]: got %0d expected %0d", i, c_c, e.cnt); end
    end
    clear = 1'b0;
  endtask

  task automatic test_async_reset();
    bit zv[4] = '{0, 0, 0, 1};
    int yv[4] = '{1, 2, 3, 3};
    exp_t e;
    do_clear();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      w = 1'b1; en = 1'b1;
      e.z = 1'b0; e.y = 32'(i + 1); e.cnt = ecnt(i + 1);
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      n_checks++;
      if (z_d !== e.z) begin n_fail++; $display("FAIL arst_pre_z[%0d]: got %b expected %b", i, z_d, e.z); end
      @(posedge clk);
      #1;
      n_checks++;
      if (32'(y_d) !== e.y) begin n_fail++; $display("FAIL arst_pre_y[%0d]: got %0d expected %0d", i, y_d, e.y); end
      n_checks++;
      if (32'(c_c) !== e.cnt) begin n_fail++; $display("FAIL arst_pre_cnt_c[%0d]: got %0d expected %0d", i, c_c, e.cnt); end
    end
    // pulse reset between edges; state must clear without a clock edge
    @(negedge clk);
    w = 1'b0; en = 1'b0;
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if (32'(y_d) !== 32'd0) begin n_fail++; $display("FAIL arst_y_d: got %0d expected 0", y_d); end
    n_checks++;
    if (32'(c_d) !== 32'd0) begin n_fail++; $display("FAIL arst_cnt_d: got %0d expected 0", c_d); end
    n_checks++;
    if (32'(c_c) !== 32'd0) begin n_fail++; $display("FAIL arst_cnt_c: got %0d expected 0", c_c); end
    n_checks++;
    if (32'(y_a) !== 32'd0) begin n_fail++; $display("FAIL arst_y_a: got %0d expected 0", y_a); end
    #1 reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      w = 1'b1; en = 1'b1;
      e.z = zv[i]; e.y = 32'(yv[i]); e.cnt = ecnt(i == 3 ? 1 : 0);
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      n_checks++;
      if (z_d !== e.z) begin n_fail++; $display("FAIL arst_post_z[%0d]: got %b expected %b", i, z_d, e.z); end
      @(posedge clk);
      #1;
      n_checks++;
      if (32'(y_d) !== e.y) begin n_fail++; $display("FAIL arst_post_y[%0d]: got %0d expected %0d", i, y_d, e.y); end
      n_checks++;
      if (32'(c_d) !== e.cnt) begin n_fail++; $display("FAIL arst_post_cnt[%0d]: got %0d expected %0d", i, c_d, e.cnt); end
    end
  endtask

  // RUN_LEN=2 overlapping against an independent "last two inputs were 1" model
  task automatic test_two_state();
    bit   prev;
    int   cnt_m;
    bit   wi;
    exp_t e;
    do_clear();
    prev  = 1'b0;
    cnt_m = 0;
    for (int i = 0; i < 40; i++) begin
      wi = 1'($urandom_range(0, 1));
      @(negedge clk);
      w = wi; en = 1'b1;
      e.z = wi & prev;
      if (e.z && cnt_m < 255) cnt_m++;
      prev = wi;
      e.y = 32'(prev); e.cnt = ecnt(cnt_m);
      sb.push_back(e);
      #1;
      e = sb.pop_front();
      n_checks++;
      if (z_e !== e.z) begin n_fail++; $display("FAIL two_state_z[%0d]: got %b expected %b", i, z_e, e.z); end
      @(posedge clk);
      #1;
      n_checks++;
      if (32'(y_e) !== e.y) begin n_fail++; $display("FAIL two_state_y[%0d]: got %0d expected %0d", i, y_e, e.y); end
      n_checks++;
      if (32'(c_e) !== e.cnt) begin n_fail++; $display("FAIL two_state_cnt[%0d]: got %0d expected %0d", i, c_e, e.cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_no_overlap();
    test_enable();
    test_saturate();
    test_async_reset();
    test_two_state();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mealy_run_detector.md
MEALY_RUN_DETECTOR -- requirements
Module: mealy_run_detector

Interface
REQ-001 Parameter RUN_LEN, default 2: number of consecutive w=1 samples that asserts z; legal range 1..255.
REQ-002 Parameter OVERLAP, default 1: 1 = overlapping runs (z stays high while w stays 1); 0 = non-overlapping (count restarts after each match).
REQ-003 Parameter CNT_W, default 8: width of match_cnt; legal range 1..32.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 w  input  1  serial data bit.
REQ-007 en  input  1  sample enable; w is evaluated only when en=1.
REQ-008 clear  input  1  synchronous clear of state and counter.
REQ-009 z  output  1  Mealy match output, combinational.
REQ-010 y  output  SW  current run state, where SW = max(1, clog2(RUN_LEN)).
REQ-011 match_cnt  output  CNT_W  saturating count of cycles in which z=1.

Function
REQ-012 y SHALL hold the number of consecutive accepted 1s, capped at RUN_LEN-1.
REQ-013 z SHALL equal en & ~clear & w & (y == RUN_LEN-1) in the same cycle as w, with zero latency and no register.
REQ-014 On a clock edge with en=1, clear=0 and w=0, y SHALL go to 0.
REQ-015 On a clock edge with en=1, clear=0, w=1 and y < RUN_LEN-1, y SHALL increment by 1.
REQ-016 On a clock edge with en=1, clear=0, w=1 and y = RUN_LEN-1, y SHALL hold when OVERLAP=1 and SHALL go to 0 when OVERLAP=0.
REQ-017 With en=0 and clear=0, y and match_cnt SHALL hold and z SHALL be 0.
REQ-018 clear=1 SHALL override en and w: on the edge, y goes to 0 and match_cnt goes to 0; z is 0 during that cycle.
REQ-019 match_cnt SHALL increment by 1 on every edge where z=1, and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-020 When RUN_LEN=1, y SHALL stay 0 and z SHALL equal en & ~clear & w; OVERLAP has no effect.
REQ-021 When RUN_LEN=2 and OVERLAP=1, with en held at 1, z SHALL be identical to a two-state "last two inputs were 1" Mealy detector.

Reset
REQ-022 reset=0 SHALL force y=0 and match_cnt=0 immediately, independent of clk.
REQ-023 During reset, z SHALL still follow REQ-013 with y=0.
REQ-024 Reset asserted mid-run SHALL discard the partial run; counting restarts from 0 after reset is released.

Configuration
REQ-025 Macro MEALY_RUN_DETECTOR_MATCH_CNT_EN, when defined, SHALL compile in the match counter as specified in REQ-019.
REQ-026 When MEALY_RUN_DETECTOR_MATCH_CNT_EN is undefined, match_cnt SHALL be tied to 0, no counter flops SHALL exist, and all other behaviour SHALL be unchanged.

Structure
REQ-027 Shared package mealy_pkg SHALL hold the state-width function (clog2 with a minimum of 1) and the named constants OVERLAP_ON=1 and OVERLAP_OFF=0.
REQ-028 The saturating counter SHALL be the sub-module sat_counter (parameter W; ports clk, reset, clr, inc, q), instantiated only under the macro.

Verification
REQ-029 RUN_LEN=3, OVERLAP=1, en=1, w=1,1,1,1,0,1 -> z=0,0,1,1,0,0 and final match_cnt=2.
REQ-030 RUN_LEN=3, OVERLAP=0, en=1, w=1,1,1,1,1,1 -> z=0,0,1,0,0,1 and y=1,2,0,1,2,0 after each edge.
REQ-031 RUN_LEN=3, w held at 1 with en=1,0,1,1 -> z=0,0,0,1; y holds at 1 while en=0.
REQ-032 CNT_W=2, RUN_LEN=1, w=1 and en=1 for 5 edges -> match_cnt=1,2,3,3,3; then clear=1 for one edge -> match_cnt=0, y=0.
REQ-033 RUN_LEN=4, after three 1s (y=3), reset pulsed low between clock edges -> y=0 and match_cnt=0 immediately; the next four 1s give z=0,0,0,1.
REQ-034 Without MEALY_RUN_DETECTOR_MATCH_CNT_EN, re-running REQ-029 -> identical z sequence and match_cnt=0 throughout.
